ts_param_exec_core: RTL

- Parametrised successor to the fixed 8x16 register-file processor top.
- Accepts 32-bit instructions over a valid/ready handshake and executes them against an NREG x DW register file with an ALU and a multi-cycle shift-add multiplier.
- Exposes the flattened register file, ZNCV status, a retire counter and an illegal-instruction pulse.
- Sits between the instruction source (microsequencer or test ROM) and debug/display logic.

---
 rtl/ts_param_exec_core.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ts_param_exec_core.sv
// ============================================================================
// Module   : ts_param_exec_core
// Purpose  : Parametrised instruction-execution core. Accepts 32-bit
//            instructions over a valid/ready handshake and executes them
//            against an NREG x DW register file using a single-cycle ALU and
//            a DW-iteration shift-add multiplier.
// Ports    : CLK, Reset (async, active-high)
//            inst[31:0], inst_valid, inst_ready    - instruction handshake
//            rf_flat[NREG*DW-1:0]                  - register i at [i*DW +: DW]
//            status[3:0] {V,C,N,Z}, busy, illegal, retire_cnt[CNT_W-1:0]
//            trace_dd/aa/bb/fs[4:0]                - only with TS_EXEC_TRACE_EN
// Options  : TS_EXEC_TRACE_EN adds the trace_* outputs (fields of the last
//            retired instruction).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_param_exec_core #(
  parameter int DW    = 16,
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [31:0]              inst,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  output logic [(2**RA_W)*DW-1:0]  rf_flat,
  output logic [3:0]               status,
  output logic                     busy,
  output logic                     illegal,
  output logic [CNT_W-1:0]         retire_cnt
`ifdef TS_EXEC_TRACE_EN
  ,
  output logic [4:0]               trace_dd,
  output logic [4:0]               trace_aa,
  output logic [4:0]               trace_bb,
  output logic [4:0]               trace_fs
`endif
);

  localparam int NREG = 2**RA_W;
  localparam int MC_W = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_MOVA = 7'h01;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_SUB  = 7'h03;
  localparam logic [6:0] OP_AND  = 7'h04;
  localparam logic [6:0] OP_OR   = 7'h05;
  localparam logic [6:0] OP_XOR  = 7'h06;
  localparam logic [6:0] OP_NOT  = 7'h07;
  localparam logic [6:0] OP_SHL  = 7'h08;
  localparam logic [6:0] OP_SHR  = 7'h09;
  localparam logic [6:0] OP_LDI  = 7'h0A;
  localparam logic [6:0] OP_MUL  = 7'h0C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         inst_q, inst_d;
  logic [DW-1:0]       rf_q [NREG];
  logic [DW-1:0]       rf_d [NREG];
  logic [3:0]          status_q, status_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic                illegal_q, illegal_d;
  logic [2*DW-1:0]     mul_acc_q, mul_acc_d;
  logic [2*DW-1:0]     mul_mcand_q, mul_mcand_d;
  logic [DW-1:0]       mul_mplier_q, mul_mplier_d;
  logic [MC_W-1:0]     mul_cnt_q, mul_cnt_d;
  logic [RA_W-1:0]     mul_dd_q, mul_dd_d;

  // Decode of the latched instruction
  logic [6:0]          opcode;
  logic [4:0]          dd_f, aa_f, bb_f;
  logic [9:0]          imm_f;
  logic [RA_W-1:0]     dd, aa, bb;
  logic [DW-1:0]       a, b, res;
  logic [DW:0]         sum, diff;
  logic                c_f, v_f, known, use_a, use_b, use_d, legal, retire;
  logic [2*DW-1:0]     acc_step;

  assign opcode = inst_q[31:25];
  assign dd_f   = inst_q[24:20];
  assign aa_f   = inst_q[19:15];
  assign bb_f   = inst_q[14:10];
  assign imm_f  = inst_q[9:0];
  assign dd     = dd_f[RA_W-1:0];
  assign aa     = aa_f[RA_W-1:0];
  assign bb     = bb_f[RA_W-1:0];
  assign a      = rf_q[aa];
  assign b      = rf_q[bb];

  // ALU result, carry/overflow and field-usage decode
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res   = '0;
    c_f   = 1'b0;
    v_f   = 1'b0;
    known = 1'b1;
    use_a = 1'b0;
    use_b = 1'b0;
    use_d = 1'b1;
    case (opcode)
      OP_NOP:  use_d = 1'b0;
      OP_MOVA: begin use_a = 1'b1; res = a; end
      OP_ADD: begin
        use_a = 1'b1; use_b = 1'b1;
        res = sum[DW-1:0];
        c_f = sum[DW];
        v_f = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        use_a = 1'b1; use_b = 1'b1;
        res = diff[DW-1:0];
        c_f = ~diff[DW];  // no borrow means A >= B
        v_f = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND:  begin use_a = 1'b1; use_b = 1'b1; res = a & b; end
      OP_OR:   begin use_a = 1'b1; use_b = 1'b1; res = a | b; end
      OP_XOR:  begin use_a = 1'b1; use_b = 1'b1; res = a ^ b; end
      OP_NOT:  begin use_a = 1'b1; res = ~a; end
      OP_SHL:  begin use_a = 1'b1; res = a << 1; c_f = a[DW-1]; end
      OP_SHR:  begin use_a = 1'b1; res = a >> 1; c_f = a[0]; end
      OP_LDI:  res = DW'(imm_f);  // zero-extend or truncate
      OP_MUL:  begin use_a = 1'b1; use_b = 1'b1; end
      default: begin known = 1'b0; use_d = 1'b0; end
    endcase
  end

  // A used register field must not carry bits above the address width
  assign legal = known
              && !(use_d && ((dd_f >> RA_W) != 5'd0))
              && !(use_a && ((aa_f >> RA_W) != 5'd0))
              && !(use_b && ((bb_f >> RA_W) != 5'd0));

  assign acc_step = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    rf_d         = rf_q;
    status_d     = status_q;
    retire_cnt_d = retire_cnt_q;
    illegal_d    = 1'b0;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    mul_dd_d     = mul_dd_q;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (!legal) begin
          illegal_d = 1'b1;
        end else if (opcode == OP_MUL) begin
          // Operands captured here so later writes to R[DD] cannot disturb them
          mul_acc_d    = '0;
          mul_mcand_d  = {{DW{1'b0}}, a};
          mul_mplier_d = b;
          mul_cnt_d    = '0;
          mul_dd_d     = dd;
          state_d      = S_MUL;
        end else begin
          if (opcode != OP_NOP) begin
            rf_d[dd] = res;
            status_d = {v_f, c_f, res[DW-1], (res == '0)};
          end
          retire_cnt_d = retire_cnt_q + 1'b1;
          retire       = 1'b1;
        end
      end
      S_MUL: begin
        mul_acc_d    = acc_step;
        mul_mcand_d  = mul_mcand_q << 1;
        mul_mplier_d = mul_mplier_q >> 1;
        mul_cnt_d    = mul_cnt_q + 1'b1;
        if (mul_cnt_q == MC_W'(DW - 1)) begin
          rf_d[mul_dd_q] = acc_step[DW-1:0];
          status_d       = {1'b0, |acc_step[2*DW-1:DW], acc_step[DW-1],
                            (acc_step[DW-1:0] == '0)};
          retire_cnt_d   = retire_cnt_q + 1'b1;
          retire         = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      inst_q       <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      status_q     <= '0;
      retire_cnt_q <= '0;
      illegal_q    <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
      mul_dd_q     <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      rf_q         <= rf_d;
      status_q     <= status_d;
      retire_cnt_q <= retire_cnt_d;
      illegal_q    <= illegal_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_dd_q     <= mul_dd_d;
    end
  end

`ifdef TS_EXEC_TRACE_EN
  logic [4:0] trace_dd_q, trace_dd_d, trace_aa_q, trace_aa_d;
  logic [4:0] trace_bb_q, trace_bb_d, trace_fs_q, trace_fs_d;

  // inst_q stays stable through MUL, so the fields are valid on either retire path
  always_comb begin
    trace_dd_d = trace_dd_q;
    trace_aa_d = trace_aa_q;
    trace_bb_d = trace_bb_q;
    trace_fs_d = trace_fs_q;
    if (retire) begin
      trace_dd_d = dd_f;
      trace_aa_d = aa_f;
      trace_bb_d = bb_f;
      trace_fs_d = opcode[4:0];
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      trace_dd_q <= '0;
      trace_aa_q <= '0;
      trace_bb_q <= '0;
      trace_fs_q <= '0;
    end else begin
      trace_dd_q <= trace_dd_d;
      trace_aa_q <= trace_aa_d;
      trace_bb_q <= trace_bb_d;
      trace_fs_q <= trace_fs_d;
    end
  end

  assign trace_dd = trace_dd_q;
  assign trace_aa = trace_aa_q;
  assign trace_bb = trace_bb_q;
  assign trace_fs = trace_fs_q;
`endif

  for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
    assign rf_flat[gi*DW +: DW] = rf_q[gi];
  end

  assign inst_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign illegal    = illegal_q;
  assign status     = status_q;
  assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire
